// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder
// Signals: in_valid/in_ready, A, B, Pin, SUB (operand side); out_valid/out_ready, S, Pout (result side).
// OVF and Z exist only when PIPE_ADDER_FLAGS_EN is defined.
// Modports: master = producer/consumer side, slave = adder side.
interface pipelined_adder_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, Pin, SUB, out_valid, out_ready, Pout;
  logic [WIDTH-1:0] A, B, S;
`ifdef PIPE_ADDER_FLAGS_EN
  logic OVF, Z;
  modport master(output in_valid, A, B, Pin, SUB, out_ready, input in_ready, out_valid, S, Pout, OVF, Z);
  modport slave(input in_valid, A, B, Pin, SUB, out_ready, output in_ready, out_valid, S, Pout, OVF, Z);
`else
  modport master(output in_valid, A, B, Pin, SUB, out_ready, input in_ready, out_valid, S, Pout);
  modport slave(input in_valid, A, B, Pin, SUB, out_ready, output in_ready, out_valid, S, Pout);
`endif
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-registered chunks with valid/ready flow control
// Ports: clk, rst (sync, active-high), bus (pipelined_adder_if.slave: operands in, S/Pout out).
// WIDTH must be a multiple of STAGES. Define PIPE_ADDER_FLAGS_EN to add the pipelined OVF and Z flags.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst,
  pipelined_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;
  logic adv, ce;
  logic [WIDTH-1:0] be;
  assign be = bus.SUB ? ~bus.B : bus.B;
  assign ce = bus.SUB | bus.Pin;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g
    // stage k sees only the operand chunks it and later stages still need
    localparam int RW = WIDTH - k * CW;
    logic [RW-1:0] a_i, b_i;
    logic c_i, v_i, c_q, v_q;
    logic [CW:0] sum;
    logic [(k+1)*CW-1:0] s_d, s_q;
`ifdef PIPE_ADDER_FLAGS_EN
    logic z_i, z_q;
`endif
    if (k == 0) begin : g_in
      assign a_i = bus.A;
      assign b_i = be;
      assign c_i = ce;
      assign v_i = bus.in_valid;
      assign s_d = sum[CW-1:0];
`ifdef PIPE_ADDER_FLAGS_EN
      assign z_i = 1'b1;
`endif
    end else begin : g_in
      assign a_i = g[k-1].g_sk.a_q;
      assign b_i = g[k-1].g_sk.b_q;
      assign c_i = g[k-1].c_q;
      assign v_i = g[k-1].v_q;
      // completed low chunks ride along so the whole result lands together
      assign s_d = {sum[CW-1:0], g[k-1].s_q};
`ifdef PIPE_ADDER_FLAGS_EN
      assign z_i = g[k-1].z_q;
`endif
    end
    assign sum = {1'b0, a_i[CW-1:0]} + {1'b0, b_i[CW-1:0]} + (CW+1)'(c_i);
    always_ff @(posedge clk)
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
`ifdef PIPE_ADDER_FLAGS_EN
        z_q <= 1'b0;
`endif
      end else if (adv) begin
        v_q <= v_i;
        c_q <= sum[CW];
        s_q <= s_d;
`ifdef PIPE_ADDER_FLAGS_EN
        z_q <= z_i & ~|sum[CW-1:0];
`endif
      end
    if (k < STAGES - 1) begin : g_sk
      logic [RW-CW-1:0] a_q, b_q;
      always_ff @(posedge clk)
        if (adv) begin
          a_q <= a_i[RW-1:CW];
          b_q <= b_i[RW-1:CW];
        end
    end
    if (k == STAGES - 1) begin : g_out
      assign bus.out_valid = v_q;
      assign bus.S = s_q;
      assign bus.Pout = c_q;
`ifdef PIPE_ADDER_FLAGS_EN
      // the top chunk's operands still carry the sign bits of A and Be
      logic ovf_q;
      always_ff @(posedge clk)
        if (rst) ovf_q <= 1'b0;
        else if (adv) ovf_q <= (a_i[CW-1] == b_i[CW-1]) && (sum[CW-1] != a_i[CW-1]);
      assign bus.OVF = ovf_q;
      assign bus.Z = z_q;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of pipelined_adder against an arithmetic reference model
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int ST = 4;
  typedef struct {
    logic [63:0] s;
    logic p;
    logic ovf;
    logic z;
    int acc;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ret_total = 0;
  res_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pipelined_adder_if #(.WIDTH(W)) bus();
  pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference: plain modular and signed integer arithmetic on w-bit operands
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic pin, input logic sub);
    res_t r;
    logic [64:0] full;
    logic [63:0] mask;
    logic signed [66:0] s_a, s_b, s_r, lim;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b} + {64'd0, pin});
    r.s = full[63:0] & mask;
    r.p = sub ? (a >= b) : full[w];
    lim = 67'sd1 <<< (w - 1);
    s_a = $signed({3'b0, a});
    if (a[w-1]) s_a = s_a - (lim <<< 1);
    s_b = $signed({3'b0, b});
    if (b[w-1]) s_b = s_b - (lim <<< 1);
    s_r = sub ? s_a - s_b : s_a + s_b + $signed({66'd0, pin});
    r.ovf = (s_r >= lim) || (s_r < -lim);
    r.z = r.s == 64'd0;
    r.acc = 0;
    return r;
  endfunction

  // main scoreboard: every presented beat must match the oldest outstanding accepted beat
  initial forever begin
    @(negedge clk);
    if (rst) q.delete();
    else begin
      chk(bus.in_ready == (!bus.out_valid || bus.out_ready), "in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid) begin
        chk(q.size() != 0, "no_stale_beat", q.size(), 1);
        if (q.size() != 0) begin
          chk(bus.S == q[0].s[W-1:0], "S", bus.S, q[0].s[W-1:0]);
          chk(bus.Pout == q[0].p, "Pout", bus.Pout, q[0].p);
`ifdef PIPE_ADDER_FLAGS_EN
          chk(bus.OVF == q[0].ovf, "OVF", bus.OVF, q[0].ovf);
          chk(bus.Z == q[0].z, "Z", bus.Z, q[0].z);
`endif
          if (bus.out_ready) begin
            void'(q.pop_front());
            ret_total++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(W, {32'd0, bus.A}, {32'd0, bus.B}, bus.Pin, bus.SUB));
    end
  end

  // entered and left #1 after a rising edge; acc is the cycle number in which the beat was accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic pin, input logic sub, output int acc);
    bus.A = a;
    bus.B = b;
    bus.Pin = pin;
    bus.SUB = sub;
    bus.in_valid = 1'b1;
    #1;
    for (int t = 0; t < 60 && !bus.in_ready; t++) begin
      @(posedge clk);
      #2;
    end
    chk(bus.in_ready, "accept_timeout", bus.in_ready, 1'b1);
    acc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic pin, input logic sub,
                          input logic [W-1:0] es, input logic ep, input logic eovf, input logic ez);
    res_t m;
    int acc;
    m = model(W, {32'd0, a}, {32'd0, b}, pin, sub);
    chk(m.s[W-1:0] == es && m.p == ep && m.ovf == eovf && m.z == ez, "model_pin",
        {m.s[W-1:0], m.p, m.ovf, m.z}, {es, ep, eovf, ez});
    send(a, b, pin, sub, acc);
    for (int t = 0; t < 20 && !bus.out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    chk(bus.out_valid && cyc - acc == ST, "latency", cyc - acc, ST);
    chk(bus.S == es, "directed_S", bus.S, es);
    chk(bus.Pout == ep, "directed_Pout", bus.Pout, ep);
`ifdef PIPE_ADDER_FLAGS_EN
    chk(bus.OVF == eovf, "directed_OVF", bus.OVF, eovf);
    chk(bus.Z == ez, "directed_Z", bus.Z, ez);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    for (int t = 0; t < 60 && q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk(q.size() == 0, nm, q.size(), 0);
  endtask

  // parameter sweep: free-running streams on separate instances with exact-latency checks
  for (genvar i = 0; i < 3; i++) begin : sw
    localparam int SWW = i == 0 ? 8 : i == 1 ? 16 : 64;
    localparam int SWS = i == 0 ? 1 : i == 1 ? 2 : 8;
    logic srst = 1'b1;
    logic done = 1'b0;
    res_t sq[$];
    pipelined_adder_if #(.WIDTH(SWW)) sbus();
    pipelined_adder #(.WIDTH(SWW), .STAGES(SWS)) sdut (.clk(clk), .rst(srst), .bus(sbus));
    initial begin
      res_t m;
      forever begin
        @(negedge clk);
        if (!srst) begin
          if (sbus.out_valid) begin
            chk(sq.size() != 0, $sformatf("sweep%0d_no_stale", i), sq.size(), 1);
            if (sq.size() != 0) begin
              chk(sbus.S == sq[0].s[SWW-1:0] && sbus.Pout == sq[0].p, $sformatf("sweep%0d_result", i),
                  {sbus.Pout, sbus.S}, {sq[0].p, sq[0].s[SWW-1:0]});
              chk(cyc - sq[0].acc == SWS, $sformatf("sweep%0d_latency", i), cyc - sq[0].acc, SWS);
              void'(sq.pop_front());
            end
          end
          if (sbus.in_valid && sbus.in_ready) begin
            m = model(SWW, 64'(sbus.A), 64'(sbus.B), sbus.Pin, sbus.SUB);
            m.acc = cyc;
            sq.push_back(m);
          end
        end
      end
    end
    initial begin
      logic [63:0] ra, rb, ones;
      res_t m;
      sbus.in_valid = 1'b0;
      sbus.A = '0;
      sbus.B = '0;
      sbus.Pin = 1'b0;
      sbus.SUB = 1'b0;
      sbus.out_ready = 1'b1;
      ones = (SWW == 64) ? '1 : ((64'd1 << SWW) - 64'd1);
      m = model(SWW, ones, 64'd1, 1'b0, 1'b0);
      chk(m.s == 64'd0 && m.p, $sformatf("sweep%0d_model_pin", i), {m.p, m.s}, {1'b1, 64'd0});
      repeat (2) @(posedge clk);
      #1;
      srst = 1'b0;
      for (int n = 0; n < 24; n++) begin
        ra = (n == 0) ? '1 : {$urandom, $urandom};
        rb = (n == 0) ? 64'd1 : {$urandom, $urandom};
        sbus.A = ra[SWW-1:0];
        sbus.B = rb[SWW-1:0];
        sbus.Pin = (n == 0) ? 1'b0 : 1'($urandom);
        sbus.SUB = (n == 0) ? 1'b0 : 1'($urandom);
        sbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
      end
      sbus.in_valid = 1'b0;
      repeat (SWS + 2) @(posedge clk);
      #1;
      chk(sq.size() == 0, $sformatf("sweep%0d_drained", i), sq.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int acc, r0;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Pin = 1'b0;
    bus.SUB = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(bus.out_valid == 1'b0, "reset_out_valid", bus.out_valid, 0);
    chk(bus.S == '0, "reset_S", bus.S, 0);
    chk(bus.Pout == 1'b0, "reset_Pout", bus.Pout, 0);
    chk(bus.in_ready == 1'b1, "reset_in_ready", bus.in_ready, 1);
`ifdef PIPE_ADDER_FLAGS_EN
    chk(bus.OVF == 1'b0 && bus.Z == 1'b0, "reset_flags", {bus.OVF, bus.Z}, 0);
`endif
    directed(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed(32'h00FF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    directed(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    // back-to-back stream: retire count pins both latency and one-beat-per-cycle throughput
    r0 = ret_total;
    for (int i = 0; i < 16; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom), acc);
    repeat (ST - 1) @(posedge clk);
    #1;
    chk(ret_total - r0 == 15, "stream_retired_early", ret_total - r0, 15);
    @(posedge clk);
    #1;
    chk(ret_total - r0 == 16, "stream_retired", ret_total - r0, 16);
    chk(q.size() == 0, "stream_drained", q.size(), 0);
    // backpressure with a full pipe, then release
    r0 = ret_total;
    bus.out_ready = 1'b0;
    for (int i = 0; i < ST; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom), acc);
    bus.A = $urandom;
    bus.B = $urandom;
    bus.Pin = 1'b1;
    bus.SUB = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk(bus.in_ready == 1'b0, "stall_in_ready", bus.in_ready, 0);
      chk(bus.out_valid == 1'b1, "stall_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(bus.A, bus.B, bus.Pin, bus.SUB, acc);
    wait_drain("stall_drained");
    chk(ret_total - r0 == ST + 1, "stall_retired", ret_total - r0, ST + 1);
    // random gaps on both sides
    r0 = ret_total;
    fork
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk);
          #1;
        end
        send($urandom, $urandom, 1'($urandom), 1'($urandom), acc);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          bus.out_ready = 1'($urandom);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("random_drained");
    chk(ret_total - r0 == 20, "random_retired", ret_total - r0, 20);
    // reset with three beats in flight
    r0 = ret_total;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk(bus.out_valid == 1'b0, "flush_out_valid", bus.out_valid, 0);
    chk(bus.S == '0, "flush_S", bus.S, 0);
    rst = 1'b0;
    chk(bus.in_ready == 1'b1, "flush_in_ready", bus.in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    chk(ret_total == r0, "flush_no_emit", ret_total - r0, 0);
    for (int t = 0; t < 200 && !(sw[0].done && sw[1].done && sw[2].done); t++) @(posedge clk);
    chk(sw[0].done && sw[1].done && sw[2].done, "sweep_done", {sw[0].done, sw[1].done, sw[2].done}, 3'b111);
    chk(q.size() == 0, "main_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the combinational ripple-carry adder. Splits a WIDTH-bit add/subtract into STAGES carry-registered chunks, so one chunk's ripple chain sits between flops and the clock can run faster. A valid/ready handshake lets the block sit between a producer and a consumer that may stall. Intended as the arithmetic core for the upcoming ALU datapath.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline depth = number of chunks; chunk width CW = WIDTH/STAGES; STAGES ≥ 1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Pin  in  1  carry-in (add mode only)
- SUB  in  1  1 = A − B, 0 = A + B + Pin
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- S  out  WIDTH  sum/difference
- Pout  out  1  carry-out of MSB (add: carry; sub: 1 = no borrow)
- OVF  out  1  signed overflow (only with PIPE_ADDER_FLAGS_EN)
- Z  out  1  S == 0 (only with PIPE_ADDER_FLAGS_EN)

## Operation
- Effective operand Be = SUB ? ~B : B; effective carry-in Ce = SUB ? 1 : Pin (Pin ignored when SUB=1).
- Stage k (0..STAGES−1) adds chunk k of A and Be plus the carry registered by stage k−1 (stage 0 uses Ce); it registers chunk sum, carry, and valid bit.
- Operand chunks not yet consumed are skewed forward in registers; completed result chunks are deskewed so that all of S appears at once at the last stage.
- Pout = carry out of stage STAGES−1. OVF = (A[MSB] == Be[MSB]) && (S[MSB] != A[MSB]). Z = ~|S.
- Flow control: global enable adv = !out_valid || out_ready. in_ready = adv. When adv = 1, every stage register (data and valid) shifts by one; when 0, everything holds. Bubbles do not collapse.
- Beat accepted when in_valid && in_ready; beat retired when out_valid && out_ready.
- Results emerge in acceptance order; no reordering, no dropping.
- S, Pout, OVF, Z are held stable while out_valid && !out_ready.
- STAGES = 1: single register stage, full WIDTH ripple, latency 1.

## Timing
- Reset: all valid bits 0; out_valid = 0, S = 0, Pout = 0, OVF = 0, Z = 0; in_ready = 1 in the first cycle after reset.
- Reset mid-operation flushes all in-flight beats; none are emitted afterward.
- Latency: a beat accepted at edge n is presented with out_valid = 1 after edge n+STAGES, with no stall.
- Throughput: 1 beat/cycle while out_ready = 1.
- in_ready depends combinationally on out_ready (single-level path, no loop through in_valid).
- Simultaneous accept and retire in the same cycle are allowed and are the steady state.
- Wrap-around: arithmetic is modulo 2^WIDTH; overflow is reported only via Pout/OVF.

## Configuration
- PIPE_ADDER_FLAGS_EN defined: the OVF and Z ports exist. The MSB operand signs and the Z reduction are pipelined alongside the data, with the same latency and stall behaviour as S.
- Not defined: the OVF and Z ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset then single add, WIDTH=32, STAGES=4: A=0xFFFF_FFFF, B=1, Pin=0, SUB=0 -> 4 cycles later out_valid=1, S=0, Pout=1, Z=1, OVF=0.
- Subtract: A=5, B=7, SUB=1, Pin=1 (ignored) -> S=0xFFFF_FFFE, Pout=0, OVF=0. Then A=0x8000_0000, B=1, SUB=1 -> S=0x7FFF_FFFF, OVF=1.
- Cross-chunk carry: A=0x00FF_FFFF, B=1 -> S=0x0100_0000. Back-to-back stream of 16 random beats -> outputs match the model in order, one per cycle.
- Backpressure: out_ready held 0 for 6 cycles with a full pipe -> in_ready=0, S held stable, no beat lost or duplicated. On release, the 4 stored results drain in order.
- Reset asserted with 3 beats in flight -> next cycle out_valid=0, S=0. No stale beat is ever emitted.
- Parameter sweep (WIDTH,STAGES) = (8,1), (16,2), (64,8) -> latency equals STAGES; random vectors match the model.
